// File: rtl/mcore_util_fill_mc_if.sv
// Bus bundle for the multi-channel fill engine: the PS register port plus the
// AXI4-Lite write channel. The engine uses the master modport (it masters AXI
// and serves register accesses); the environment uses the slave modport.
interface mcore_util_fill_mc_if #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 32
);

    // Register port
    logic [ADDR_WIDTH-1:0]     mr_addra;
    logic [DATA_WIDTH-1:0]     mr_dina;
    logic [DATA_WIDTH-1:0]     mr_douta;
    logic                      mr_ena;
    logic [DATA_WIDTH/8-1:0]   mr_wea;

    // AXI4-Lite write channels
    logic [AXI_ADDR_WIDTH-1:0] m_axi_aw_addr;
    logic [2:0]                m_axi_aw_prot;
    logic                      m_axi_aw_valid;
    logic                      m_axi_aw_ready;
    logic [DATA_WIDTH-1:0]     m_axi_w_data;
    logic [DATA_WIDTH/8-1:0]   m_axi_w_strb;
    logic                      m_axi_w_valid;
    logic                      m_axi_w_ready;
    logic [1:0]                m_axi_b_resp;
    logic                      m_axi_b_valid;
    logic                      m_axi_b_ready;

    modport master (
        input  mr_addra, mr_dina, mr_ena, mr_wea,
        output mr_douta,
        output m_axi_aw_addr, m_axi_aw_prot, m_axi_aw_valid,
        input  m_axi_aw_ready,
        output m_axi_w_data, m_axi_w_strb, m_axi_w_valid,
        input  m_axi_w_ready,
        input  m_axi_b_resp, m_axi_b_valid,
        output m_axi_b_ready
    );

    modport slave (
        output mr_addra, mr_dina, mr_ena, mr_wea,
        input  mr_douta,
        input  m_axi_aw_addr, m_axi_aw_prot, m_axi_aw_valid,
        output m_axi_aw_ready,
        input  m_axi_w_data, m_axi_w_strb, m_axi_w_valid,
        output m_axi_w_ready,
        output m_axi_b_resp, m_axi_b_valid,
        input  m_axi_b_ready
    );

endinterface

// File: rtl/mcore_util_fill_mc.sv
// Multi-channel memory fill engine. Each channel writes COUNT words starting
// at DST, either a constant PATTERN or one that grows by STEP per beat. All
// channels share one AXI4-Lite write master, granted round-robin one beat at
// a time, with at most one transaction outstanding.
module mcore_util_fill_mc #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                 aclk,
    input  logic                 arst,
    mcore_util_fill_mc_if.master bus,
    output logic                 irq
);

    localparam int unsigned ChW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned StrbW = DATA_WIDTH / 8;

    typedef logic [ChW-1:0] ch_idx_t;

    typedef enum logic [1:0] {ChIdle, ChPend, ChActive} ch_st_e;
    typedef enum logic [1:0] {MIdle, MAddr, MResp} m_st_e;

    // Programmed registers (software view)
    logic [AXI_ADDR_WIDTH-1:0] dst_q    [NUM_CH];
    logic [CNT_WIDTH-1:0]      cnt_q    [NUM_CH];
    logic [DATA_WIDTH-1:0]     pat_q    [NUM_CH];
    logic [DATA_WIDTH-1:0]     step_q   [NUM_CH];
    logic                      incr_q   [NUM_CH];
    logic                      irq_en_q [NUM_CH];

    // Working copies latched at start; these are what the run consumes
    logic [AXI_ADDR_WIDTH-1:0] wk_dst_q  [NUM_CH];
    logic [CNT_WIDTH-1:0]      wk_cnt_q  [NUM_CH];
    logic [DATA_WIDTH-1:0]     wk_pat_q  [NUM_CH];
    logic [DATA_WIDTH-1:0]     wk_step_q [NUM_CH];
    logic                      wk_incr_q [NUM_CH];

    logic                      done_q [NUM_CH];
    logic                      err_q  [NUM_CH];
    ch_st_e                    ch_st_q [NUM_CH];

    // Shared master state
    m_st_e                     m_st_q;
    ch_idx_t                   ptr_q;     // next position to start the search from
    ch_idx_t                   gnt_ch_q;  // channel owning the outstanding beat
    logic                      aw_valid_q;
    logic                      w_valid_q;
    logic                      b_ready_q;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0]     w_data_q;
    logic [DATA_WIDTH-1:0]     rd_data_q;

    // Register decode
    logic [2:0]            reg_ch_raw;
    logic [2:0]            reg_off;
    logic                  reg_hit;
    logic                  reg_wr;
    ch_idx_t               reg_ch;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  unused_addr;

    assign reg_ch_raw  = bus.mr_addra[7:5];
    assign reg_off     = bus.mr_addra[4:2];
    assign reg_hit     = 32'(reg_ch_raw) < NUM_CH;
    assign reg_ch      = ch_idx_t'(reg_ch_raw);
    assign reg_wr      = bus.mr_ena && (|bus.mr_wea);
    assign unused_addr = ^{bus.mr_addra[ADDR_WIDTH-1:8], bus.mr_addra[1:0]};

    assign bus.m_axi_aw_addr  = aw_addr_q;
    assign bus.m_axi_aw_prot  = 3'b000;
    assign bus.m_axi_aw_valid = aw_valid_q;
    assign bus.m_axi_w_data   = w_data_q;
    assign bus.m_axi_w_strb   = {StrbW{1'b1}};
    assign bus.m_axi_w_valid  = w_valid_q;
    assign bus.m_axi_b_ready  = b_ready_q;
    assign bus.mr_douta       = rd_data_q;

    function automatic ch_idx_t next_ch(input ch_idx_t c);
        return (32'(c) == NUM_CH - 1) ? '0 : c + ch_idx_t'(1);
    endfunction

    // Round-robin pick among pending channels that still have beats to issue
    logic    gnt_valid;
    ch_idx_t gnt_idx;
    ch_idx_t cand;
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        // Walk from farthest to nearest so the nearest match wins
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            cand = ch_idx_t'((32'(ptr_q) + 32'(i)) % NUM_CH);
            if (ch_st_q[cand] == ChPend && wk_cnt_q[cand] != '0) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Interrupt: any channel that is done with its interrupt enabled
    always_comb begin
        irq = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            irq = irq | (done_q[i] & irq_en_q[i]);
        end
    end

    // Register read mux
    always_comb begin
        rd_data = '0;
        if (reg_hit) begin
            case (reg_off)
                3'd0: rd_data = DATA_WIDTH'(dst_q[reg_ch]);
                3'd1: rd_data[5:0] = {irq_en_q[reg_ch], incr_q[reg_ch], 1'b0, err_q[reg_ch],
                                      ch_st_q[reg_ch] != ChIdle, done_q[reg_ch]};
                3'd2: rd_data = DATA_WIDTH'(cnt_q[reg_ch]);
                3'd3: rd_data = pat_q[reg_ch];
                3'd4: rd_data = step_q[reg_ch];
                default: rd_data = '0;
            endcase
        end
    end

    // Registered read data, held while the port is idle
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            rd_data_q <= '0;
        end else if (bus.mr_ena) begin
            rd_data_q <= rd_data;
        end
    end

    // Register writes, channel FSMs and the shared AXI master FSM
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                dst_q[i]     <= '0;
                cnt_q[i]     <= '0;
                pat_q[i]     <= '0;
                step_q[i]    <= '0;
                incr_q[i]    <= 1'b0;
                irq_en_q[i]  <= 1'b0;
                wk_dst_q[i]  <= '0;
                wk_cnt_q[i]  <= '0;
                wk_pat_q[i]  <= '0;
                wk_step_q[i] <= '0;
                wk_incr_q[i] <= 1'b0;
                done_q[i]    <= 1'b0;
                err_q[i]     <= 1'b0;
                ch_st_q[i]   <= ChIdle;
            end
            m_st_q     <= MIdle;
            ptr_q      <= '0;
            gnt_ch_q   <= '0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
        end else begin
            if (reg_wr && reg_hit) begin
                case (reg_off)
                    3'd0: dst_q[reg_ch] <= AXI_ADDR_WIDTH'(bus.mr_dina);
                    3'd1: begin
                        incr_q[reg_ch]   <= bus.mr_dina[4];
                        irq_en_q[reg_ch] <= bus.mr_dina[5];
                        // Start only from idle; mode comes from this same write
                        if (bus.mr_dina[0] && ch_st_q[reg_ch] == ChIdle) begin
                            done_q[reg_ch]    <= 1'b0;
                            err_q[reg_ch]     <= 1'b0;
                            wk_dst_q[reg_ch]  <= dst_q[reg_ch];
                            wk_cnt_q[reg_ch]  <= cnt_q[reg_ch];
                            wk_pat_q[reg_ch]  <= pat_q[reg_ch];
                            wk_step_q[reg_ch] <= step_q[reg_ch];
                            wk_incr_q[reg_ch] <= bus.mr_dina[4];
                            ch_st_q[reg_ch]   <= ChPend;
                        end
                    end
                    3'd2: cnt_q[reg_ch]  <= bus.mr_dina[CNT_WIDTH-1:0];
                    3'd3: pat_q[reg_ch]  <= bus.mr_dina;
                    3'd4: step_q[reg_ch] <= bus.mr_dina;
                    default: ;
                endcase
            end

            // A zero-length run finishes without ever being arbitrated
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (ch_st_q[i] == ChPend && wk_cnt_q[i] == '0) begin
                    ch_st_q[i] <= ChIdle;
                    done_q[i]  <= 1'b1;
                end
            end

            unique case (m_st_q)
                MIdle: begin
                    if (gnt_valid) begin
                        aw_addr_q           <= wk_dst_q[gnt_idx];
                        w_data_q            <= wk_pat_q[gnt_idx];
                        wk_dst_q[gnt_idx]   <= wk_dst_q[gnt_idx] + AXI_ADDR_WIDTH'(StrbW);
                        if (wk_incr_q[gnt_idx]) begin
                            wk_pat_q[gnt_idx] <= wk_pat_q[gnt_idx] + wk_step_q[gnt_idx];
                        end
                        wk_cnt_q[gnt_idx]   <= wk_cnt_q[gnt_idx] - CNT_WIDTH'(1);
                        ch_st_q[gnt_idx]    <= ChActive;
                        gnt_ch_q            <= gnt_idx;
                        ptr_q               <= next_ch(gnt_idx);
                        aw_valid_q          <= 1'b1;
                        w_valid_q           <= 1'b1;
                        m_st_q              <= MAddr;
                    end
                end
                MAddr: begin
                    if (bus.m_axi_aw_ready) aw_valid_q <= 1'b0;
                    if (bus.m_axi_w_ready)  w_valid_q  <= 1'b0;
                    if ((!aw_valid_q || bus.m_axi_aw_ready) &&
                        (!w_valid_q || bus.m_axi_w_ready)) begin
                        b_ready_q <= 1'b1;
                        m_st_q    <= MResp;
                    end
                end
                MResp: begin
                    if (bus.m_axi_b_valid) begin
                        b_ready_q <= 1'b0;
                        m_st_q    <= MIdle;
                        if (bus.m_axi_b_resp != 2'b00) begin
                            // Abandon the rest of this channel's run
                            err_q[gnt_ch_q]   <= 1'b1;
                            done_q[gnt_ch_q]  <= 1'b1;
                            ch_st_q[gnt_ch_q] <= ChIdle;
                        end else if (wk_cnt_q[gnt_ch_q] == '0) begin
                            done_q[gnt_ch_q]  <= 1'b1;
                            ch_st_q[gnt_ch_q] <= ChIdle;
                        end else begin
                            ch_st_q[gnt_ch_q] <= ChPend;
                        end
                    end
                end
                default: m_st_q <= MIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mcore_util_fill_mc.sv
// Directed bench for mcore_util_fill_mc: programs channels over the register
// port, records AXI traffic with a small monitor, and compares against
// hand-computed addresses, data and status words.
module tb_mcore_util_fill_mc;

    logic aclk = 1'b0;
    logic arst = 1'b1;
    logic irq;

    always #5 aclk = ~aclk;

    mcore_util_fill_mc_if #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (32),
        .AXI_ADDR_WIDTH(32)
    ) bus ();

    mcore_util_fill_mc #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (32),
        .AXI_ADDR_WIDTH(32),
        .NUM_CH        (4),
        .CNT_WIDTH     (16)
    ) dut (
        .aclk(aclk),
        .arst(arst),
        .bus (bus),
        .irq (irq)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] aw_q[$];
    logic [31:0] w_q[$];
    int          b_cnt  = 0;
    int          err_at = 0;

    // Slave answers B immediately; one chosen beat gets SLVERR
    assign bus.m_axi_b_valid = bus.m_axi_b_ready;
    assign bus.m_axi_b_resp  = (b_cnt + 1 == err_at) ? 2'b10 : 2'b00;

    // Record every completed AW, W and B handshake
    always @(posedge aclk) begin
        if (bus.m_axi_aw_valid && bus.m_axi_aw_ready) aw_q.push_back(bus.m_axi_aw_addr);
        if (bus.m_axi_w_valid && bus.m_axi_w_ready)   w_q.push_back(bus.m_axi_w_data);
        if (bus.m_axi_b_valid && bus.m_axi_b_ready)   b_cnt <= b_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // Register tasks start and end on a falling edge
    task automatic reg_wr(input logic [31:0] addr, input logic [31:0] data);
        bus.mr_addra = addr;
        bus.mr_dina  = data;
        bus.mr_wea   = 4'hf;
        bus.mr_ena   = 1'b1;
        @(negedge aclk);
        bus.mr_ena   = 1'b0;
        bus.mr_wea   = 4'h0;
    endtask

    task automatic reg_rd(input logic [31:0] addr, output logic [31:0] data);
        bus.mr_addra = addr;
        bus.mr_wea   = 4'h0;
        bus.mr_ena   = 1'b1;
        @(negedge aclk);
        data         = bus.mr_douta;
        bus.mr_ena   = 1'b0;
    endtask

    // Poll STAT until done and not busy, bounded
    task automatic wait_done(input logic [31:0] base, input string tag);
        logic [31:0] s;
        int n;
        n = 0;
        do begin
            reg_rd(base + 32'h4, s);
            n++;
        end while (!(s[0] && !s[1]) && n < 200);
        check_eq({tag, "_done"}, {31'b0, s[0] & ~s[1]}, 32'h1);
    endtask

    logic [31:0] rd;
    int          ab;
    int          wb;
    logic [31:0] exp_addr [6];
    logic [31:0] exp_data [6];
    logic [31:0] inc_data [4];

    initial begin
        bus.mr_addra       = '0;
        bus.mr_dina        = '0;
        bus.mr_ena         = 1'b0;
        bus.mr_wea         = '0;
        bus.m_axi_aw_ready = 1'b1;
        bus.m_axi_w_ready  = 1'b1;
        repeat (2) @(negedge aclk);
        arst = 1'b0;

        // Reset state
        check_eq("rst_aw_valid", {31'b0, bus.m_axi_aw_valid}, 32'h0);
        check_eq("rst_w_valid",  {31'b0, bus.m_axi_w_valid},  32'h0);
        check_eq("rst_b_ready",  {31'b0, bus.m_axi_b_ready},  32'h0);
        check_eq("rst_irq",      {31'b0, irq},                32'h0);
        check_eq("rst_douta",    bus.mr_douta,                32'h0);
        reg_rd(32'h04, rd);
        check_eq("rst_stat0", rd, 32'h0);

        // Channel 4 does not exist with four channels
        reg_wr(32'h80, 32'hdead_beef);
        reg_wr(32'h00, 32'h0000_1234);
        reg_rd(32'h00, rd);
        check_eq("dst0_rw", rd, 32'h0000_1234);
        reg_rd(32'h80, rd);
        check_eq("oor_read", rd, 32'h0);

        // 1: constant fill of 8 words
        reg_wr(32'h00, 32'h7000_0000);
        reg_wr(32'h08, 32'd8);
        reg_wr(32'h0c, 32'hcafe_0000);
        ab = aw_q.size();
        wb = w_q.size();
        reg_wr(32'h04, 32'h1);
        wait_done(32'h00, "t1");
        check_eq("t1_aw_n", 32'(aw_q.size() - ab), 32'd8);
        check_eq("t1_w_n",  32'(w_q.size() - wb),  32'd8);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("t1_addr%0d", i), aw_q[ab + i], 32'h7000_0000 + 32'(4 * i));
            check_eq($sformatf("t1_data%0d", i), w_q[wb + i], 32'hcafe_0000);
        end
        reg_rd(32'h04, rd);
        check_eq("t1_stat", rd, 32'h1);

        // 2: incrementing fill that wraps through zero
        reg_wr(32'h20, 32'h0000_0100);
        reg_wr(32'h28, 32'd4);
        reg_wr(32'h2c, 32'hffff_fffe);
        reg_wr(32'h30, 32'h1);
        wb = w_q.size();
        reg_wr(32'h24, 32'h11);
        wait_done(32'h20, "t2");
        inc_data = '{32'hffff_fffe, 32'hffff_ffff, 32'h0, 32'h1};
        check_eq("t2_w_n", 32'(w_q.size() - wb), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t2_data%0d", i), w_q[wb + i], inc_data[i]);
        end
        reg_rd(32'h24, rd);
        check_eq("t2_stat", rd, 32'h11);

        // 3: ch0 and ch2 both pending -> strict alternation
        arst = 1'b1;
        @(negedge aclk);
        arst = 1'b0;
        bus.m_axi_aw_ready = 1'b0;
        bus.m_axi_w_ready  = 1'b0;
        reg_wr(32'h00, 32'h0000_1000);
        reg_wr(32'h08, 32'd3);
        reg_wr(32'h0c, 32'h0000_00a0);
        reg_wr(32'h40, 32'h0000_2000);
        reg_wr(32'h48, 32'd3);
        reg_wr(32'h4c, 32'h0000_00c0);
        ab = aw_q.size();
        wb = w_q.size();
        reg_wr(32'h04, 32'h1);
        reg_wr(32'h44, 32'h1);
        bus.m_axi_aw_ready = 1'b1;
        bus.m_axi_w_ready  = 1'b1;
        wait_done(32'h00, "t3_ch0");
        wait_done(32'h40, "t3_ch2");
        exp_addr = '{32'h1000, 32'h2000, 32'h1004, 32'h2004, 32'h1008, 32'h2008};
        exp_data = '{32'ha0, 32'hc0, 32'ha0, 32'hc0, 32'ha0, 32'hc0};
        check_eq("t3_aw_n", 32'(aw_q.size() - ab), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("t3_addr%0d", i), aw_q[ab + i], exp_addr[i]);
            check_eq($sformatf("t3_data%0d", i), w_q[wb + i], exp_data[i]);
        end

        // 4a: AW stalled, W accepted at once
        reg_wr(32'h60, 32'h0000_3000);
        reg_wr(32'h68, 32'd1);
        reg_wr(32'h6c, 32'h0000_0033);
        bus.m_axi_aw_ready = 1'b0;
        bus.m_axi_w_ready  = 1'b1;
        ab = aw_q.size();
        wb = w_q.size();
        reg_wr(32'h64, 32'h1);
        repeat (4) @(negedge aclk);
        check_eq("t4a_aw_valid", {31'b0, bus.m_axi_aw_valid}, 32'h1);
        check_eq("t4a_w_valid",  {31'b0, bus.m_axi_w_valid},  32'h0);
        check_eq("t4a_w_n_mid",  32'(w_q.size() - wb),        32'd1);
        bus.m_axi_aw_ready = 1'b1;
        wait_done(32'h60, "t4a");
        check_eq("t4a_aw_n", 32'(aw_q.size() - ab), 32'd1);
        check_eq("t4a_w_n",  32'(w_q.size() - wb),  32'd1);
        check_eq("t4a_addr", aw_q[ab], 32'h0000_3000);

        // 4b: W stalled, AW accepted at once
        bus.m_axi_w_ready = 1'b0;
        ab = aw_q.size();
        wb = w_q.size();
        reg_wr(32'h64, 32'h1);
        repeat (4) @(negedge aclk);
        check_eq("t4b_aw_valid", {31'b0, bus.m_axi_aw_valid}, 32'h0);
        check_eq("t4b_w_valid",  {31'b0, bus.m_axi_w_valid},  32'h1);
        check_eq("t4b_aw_n_mid", 32'(aw_q.size() - ab),       32'd1);
        bus.m_axi_w_ready = 1'b1;
        wait_done(32'h60, "t4b");
        check_eq("t4b_aw_n", 32'(aw_q.size() - ab), 32'd1);
        check_eq("t4b_w_n",  32'(w_q.size() - wb),  32'd1);
        check_eq("t4b_data", w_q[wb], 32'h0000_0033);

        // 5: SLVERR on the second beat of five
        reg_wr(32'h20, 32'h0000_5000);
        reg_wr(32'h28, 32'd5);
        reg_wr(32'h2c, 32'h0000_0055);
        err_at = b_cnt + 2;
        ab = aw_q.size();
        reg_wr(32'h24, 32'h21);
        wait_done(32'h20, "t5");
        check_eq("t5_aw_n", 32'(aw_q.size() - ab), 32'd2);
        reg_rd(32'h24, rd);
        check_eq("t5_stat", rd, 32'h25);
        check_eq("t5_irq", {31'b0, irq}, 32'h1);

        // 6a: zero-length run
        reg_wr(32'h08, 32'd0);
        ab = aw_q.size();
        reg_wr(32'h04, 32'h1);
        reg_rd(32'h04, rd);
        check_eq("t6a_stat_busy", rd, 32'h2);
        reg_rd(32'h04, rd);
        check_eq("t6a_stat_done", rd, 32'h1);
        check_eq("t6a_aw_n", 32'(aw_q.size() - ab), 32'd0);
        check_eq("t6a_aw_valid", {31'b0, bus.m_axi_aw_valid}, 32'h0);

        // 6b: restart and DST rewrite while busy do not disturb the run
        reg_wr(32'h40, 32'h0000_4000);
        reg_wr(32'h48, 32'd3);
        reg_wr(32'h4c, 32'h0000_0077);
        bus.m_axi_aw_ready = 1'b0;
        bus.m_axi_w_ready  = 1'b0;
        ab = aw_q.size();
        wb = w_q.size();
        reg_wr(32'h44, 32'h1);
        reg_wr(32'h44, 32'h11);
        reg_wr(32'h40, 32'h0000_9000);
        bus.m_axi_aw_ready = 1'b1;
        bus.m_axi_w_ready  = 1'b1;
        wait_done(32'h40, "t6b");
        check_eq("t6b_aw_n", 32'(aw_q.size() - ab), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("t6b_addr%0d", i), aw_q[ab + i], 32'h4000 + 32'(4 * i));
            check_eq($sformatf("t6b_data%0d", i), w_q[wb + i], 32'h77);
        end
        reg_rd(32'h44, rd);
        check_eq("t6b_stat", rd, 32'h11);
        reg_rd(32'h40, rd);
        check_eq("t6b_dst", rd, 32'h0000_9000);

        // 6c: asynchronous reset in the middle of the address phase
        reg_wr(32'h00, 32'h0000_6000);
        reg_wr(32'h08, 32'd2);
        bus.m_axi_aw_ready = 1'b0;
        bus.m_axi_w_ready  = 1'b0;
        reg_wr(32'h04, 32'h1);
        repeat (2) @(negedge aclk);
        check_eq("t6c_aw_valid_pre", {31'b0, bus.m_axi_aw_valid}, 32'h1);
        check_eq("t6c_w_valid_pre",  {31'b0, bus.m_axi_w_valid},  32'h1);
        #2 arst = 1'b1;
        #1;
        check_eq("t6c_aw_valid_rst", {31'b0, bus.m_axi_aw_valid}, 32'h0);
        check_eq("t6c_w_valid_rst",  {31'b0, bus.m_axi_w_valid},  32'h0);
        check_eq("t6c_irq_rst",      {31'b0, irq},                32'h0);
        @(negedge aclk);
        arst = 1'b0;
        bus.m_axi_aw_ready = 1'b1;
        bus.m_axi_w_ready  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            reg_rd(32'(c * 32 + 4), rd);
            check_eq($sformatf("t6c_stat%0d", c), rd, 32'h0);
        end
        reg_rd(32'h00, rd);
        check_eq("t6c_dst0", rd, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
